// File: rtl/sum_sender_pkg.sv
// Shared types and constants for the sum frame sender.
package sum_sender_pkg;

  localparam int          SUM_W          = 40;
  localparam int          BYTES_PER_SUM  = 5;
  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    LATCH,
    SEND,
    GAP,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/sum_sender.sv
// Streams a frame of HEADER, N_SAMPLES 40-bit sums (MSB first) and an 8-bit
// payload checksum from an external sum RAM to a byte-wide UART transmitter.
module sum_sender
  import sum_sender_pkg::*;
#(
  parameter int         N_SAMPLES = 768,
  parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [9:0]       rd_addr,
  output logic             rd_en,
  input  logic [SUM_W-1:0] rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  input  logic             tx_rdy
);

  localparam logic [9:0] LAST_ADDR = 10'(N_SAMPLES - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_SUM - 1);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q;
  logic [2:0]       byte_idx_q;
  logic [9:0]       addr_q;
  logic [7:0]       csum_q;
  logic             in_payload_q;
  logic [7:0]       cur_byte;
  logic [7:0]       tx_byte;
  logic             tx_fire;

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = sum_q[39:32];
      3'd1:    cur_byte = sum_q[31:24];
      3'd2:    cur_byte = sum_q[23:16];
      3'd3:    cur_byte = sum_q[15:8];
      default: cur_byte = sum_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_byte = 8'h00;
    tx_fire = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = HDR;
      HDR: begin
        tx_byte = HEADER;
        if (tx_rdy) begin
          tx_fire = 1'b1;
          state_d = GAP;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: state_d = SEND;
      SEND: begin
        tx_byte = cur_byte;
        if (tx_rdy) begin
          tx_fire = 1'b1;
          state_d = GAP;
        end
      end
      // GAP never looks at tx_rdy; it only decides what comes next.
      GAP: begin
        if (!in_payload_q)               state_d = FETCH;
        else if (byte_idx_q < LAST_BYTE) state_d = SEND;
        else if (addr_q == LAST_ADDR)    state_d = CSUM;
        else                             state_d = FETCH;
      end
      CSUM: begin
        tx_byte = csum_q;
        if (tx_rdy) begin
          tx_fire = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sum_q        <= '0;
      byte_idx_q   <= '0;
      addr_q       <= '0;
      csum_q       <= '0;
      in_payload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          byte_idx_q   <= '0;
          addr_q       <= '0;
          csum_q       <= '0;
          in_payload_q <= 1'b0;
        end
        // The sum register is loaded only here, after all bytes of the
        // previous sample have left through SEND.
        LATCH: begin
          sum_q      <= rd_data;
          byte_idx_q <= '0;
        end
        SEND: if (tx_fire) csum_q <= csum_q + cur_byte;
        GAP: begin
          if (!in_payload_q)               in_payload_q <= 1'b1;
          else if (byte_idx_q < LAST_BYTE) byte_idx_q   <= byte_idx_q + 3'd1;
          else if (addr_q != LAST_ADDR)    addr_q       <= addr_q + 10'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == FETCH);
  assign rd_addr = addr_q;
  assign tx_en   = tx_fire;
  assign tx_data = tx_byte;

endmodule

// File: tb/tb_sum_sender.sv
// Directed bench for sum_sender: three instances (2, 768 and 3 samples)
// driven with small RAM models and a byte-capturing transmitter monitor.
module tb_sum_sender;

  localparam int NI = 3;

  logic              clk = 1'b0;
  logic [NI-1:0]     reset, start, busy, done, rd_en, tx_en, tx_rdy;
  logic [9:0]        rd_addr [NI];
  logic [39:0]       rd_data [NI];
  logic [7:0]        tx_data [NI];

  logic [39:0]       ram   [NI][1024];
  logic [7:0]        cap   [NI][4096];
  int                cnt      [NI];
  int                done_cnt [NI];
  int                rd_cnt   [NI];
  int                rd_err   [NI];
  int                rd_next  [NI];
  int                max_addr [NI];
  int                rdy_err  [NI];
  logic [NI-1:0]     rd_prev;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NS = (g == 0) ? 2 : ((g == 1) ? 768 : 3);
    sum_sender #(.N_SAMPLES(NS)) u_dut (
      .clk     (clk),
      .reset   (reset[g]),
      .start   (start[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rd_addr (rd_addr[g]),
      .rd_en   (rd_en[g]),
      .rd_data (rd_data[g]),
      .tx_data (tx_data[g]),
      .tx_en   (tx_en[g]),
      .tx_rdy  (tx_rdy[g])
    );
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0; done_cnt[i] = 0; rd_cnt[i] = 0; rd_err[i] = 0;
      rd_next[i] = 0; max_addr[i] = 0; rdy_err[i] = 0; rd_data[i] = '0;
    end
    rd_prev = '0;
  end

  // RAM model (1-cycle read latency) and transmitter / read-port monitor
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd_en[i]) rd_data[i] <= ram[i][rd_addr[i]];
      if (tx_en[i]) begin
        if (!tx_rdy[i]) rdy_err[i]++;
        if (cnt[i] < 4096) cap[i][cnt[i]] = tx_data[i];
        cnt[i]++;
      end
      if (done[i]) done_cnt[i]++;
      if (!busy[i]) rd_next[i] = 0;
      if (rd_en[i]) begin
        if (int'(rd_addr[i]) != rd_next[i] || rd_prev[i]) rd_err[i]++;
        rd_next[i] = int'(rd_addr[i]) + 1;
        rd_cnt[i]++;
        if (int'(rd_addr[i]) > max_addr[i]) max_addr[i] = int'(rd_addr[i]);
      end
    end
    rd_prev = rd_en;
  end

  typedef struct {
    string      name;
    logic [7:0] exp;
  } vec_t;
  vec_t t1 [12];

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, input string nm);
    int n = 0;
    while (!done[i] && n < limit) begin
      @(negedge clk); n++;
    end
    check({nm, "_done_seen"}, int'(done[i]), 1);
  endtask

  task automatic wait_bytes(input int i, input int target, input string nm);
    int n = 0;
    while (cnt[i] < target && n < 1000) begin
      @(negedge clk); n++;
    end
    check({nm, "_bytes_reached"}, int'(cnt[i] >= target), 1);
  endtask

  task automatic check_frame(input int base, input string nm);
    check({nm, "_len"}, cnt[0] - base, 12);
    for (int k = 0; k < 12; k++)
      check({nm, "_", t1[k].name}, int'(cap[0][base + k]), int'(t1[k].exp));
  endtask

  initial begin
    int base, d0, stall_bad, c0;
    logic [7:0] model_csum;
    logic [39:0] v;

    t1[0]  = '{"hdr",  8'hA5};
    t1[1]  = '{"s0b0", 8'h01}; t1[2]  = '{"s0b1", 8'h02};
    t1[3]  = '{"s0b2", 8'h03}; t1[4]  = '{"s0b3", 8'h04};
    t1[5]  = '{"s0b4", 8'h05};
    t1[6]  = '{"s1b0", 8'hFF}; t1[7]  = '{"s1b1", 8'hFF};
    t1[8]  = '{"s1b2", 8'hFF}; t1[9]  = '{"s1b3", 8'hFF};
    t1[10] = '{"s1b4", 8'hFF};
    t1[11] = '{"csum", 8'h0A};

    ram[0][0] = 40'h0102030405;
    ram[0][1] = 40'hFFFFFFFFFF;
    for (int n = 0; n < 1024; n++) ram[1][n] = 40'(n);
    for (int n = 0; n < 3; n++)    ram[2][n] = 40'hFFFFFFFFFF;

    reset = '1; start = '0; tx_rdy = '1;
    repeat (3) @(negedge clk);
    check("rst_busy",    int'(busy[0]),    0);
    check("rst_done",    int'(done[0]),    0);
    check("rst_rd_en",   int'(rd_en[0]),   0);
    check("rst_tx_en",   int'(tx_en[0]),   0);
    check("rst_tx_data", int'(tx_data[0]), 0);
    check("rst_rd_addr", int'(rd_addr[0]), 0);
    reset[0] = 1'b0;

    // Test 1: basic two-sample frame
    base = cnt[0];
    pulse_start(0);
    check("t1_busy", int'(busy[0]), 1);
    wait_done(0, 200, "t1");
    @(negedge clk);
    check_frame(base, "t1");
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_rd_cnt",   rd_cnt[0],   2);
    check("t1_busy_end", int'(busy[0]), 0);

    // Test 3: 50-cycle tx_rdy stall in the middle of sample 0
    base = cnt[0];
    pulse_start(0);
    wait_bytes(0, base + 3, "t3");
    tx_rdy[0] = 1'b0;
    c0 = cnt[0];
    stall_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_en[0] || !busy[0]) stall_bad++;
    end
    check("t3_stall_quiet", stall_bad, 0);
    check("t3_stall_count", cnt[0], c0);
    tx_rdy[0] = 1'b1;
    wait_done(0, 200, "t3");
    @(negedge clk);
    check_frame(base, "t3");

    // Test 4: starts while busy and coincident with done are ignored
    base = cnt[0];
    d0 = done_cnt[0];
    pulse_start(0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (10) @(negedge clk);
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_done(0, 200, "t4");
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_bytes",    cnt[0] - base,      12);
    check("t4_done_cnt", done_cnt[0] - d0,   1);
    check("t4_idle",     int'(busy[0]),      0);

    // Test 5: reset after byte 7 aborts the frame
    base = cnt[0];
    pulse_start(0);
    wait_bytes(0, base + 7, "t5");
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    check("t5_busy",    int'(busy[0]),    0);
    check("t5_done",    int'(done[0]),    0);
    check("t5_rd_en",   int'(rd_en[0]),   0);
    check("t5_tx_en",   int'(tx_en[0]),   0);
    check("t5_tx_data", int'(tx_data[0]), 0);
    check("t5_rd_addr", int'(rd_addr[0]), 0);
    c0 = cnt[0];
    repeat (20) @(negedge clk);
    check("t5_no_resume", cnt[0], c0);
    reset[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0; start[0] = 1'b0;
    @(negedge clk);
    check("t5_rst_over_start", int'(busy[0]), 0);
    base = cnt[0];
    pulse_start(0);
    wait_done(0, 200, "t5");
    @(negedge clk);
    check_frame(base, "t5_restart");

    // Test 2: full default-size frame, RAM[n] = n
    model_csum = 8'h00;
    for (int n = 0; n < 768; n++) begin
      v = 40'(n);
      for (int b = 0; b < 5; b++) model_csum = model_csum + v[39 - 8*b -: 8];
    end
    reset[1] = 1'b0;
    @(negedge clk);
    pulse_start(1);
    wait_done(1, 20000, "t2");
    @(negedge clk);
    check("t2_bytes",     cnt[1],                 3842);
    check("t2_hdr",       int'(cap[1][0]),        8'hA5);
    check("t2_max_addr",  max_addr[1],            767);
    check("t2_rd_cnt",    rd_cnt[1],              768);
    check("t2_rd_order",  rd_err[1],              0);
    check("t2_s300_b3",   int'(cap[1][1+5*300+3]), 8'h01);
    check("t2_s300_b4",   int'(cap[1][1+5*300+4]), 8'h2C);
    check("t2_last_pay",  int'(cap[1][3840]),     8'hFF);
    check("t2_csum",      int'(cap[1][3841]),     int'(model_csum));

    // Test 6: checksum wraps modulo 256
    reset[2] = 1'b0;
    @(negedge clk);
    pulse_start(2);
    wait_done(2, 500, "t6");
    @(negedge clk);
    check("t6_bytes",    cnt[2],            17);
    check("t6_csum",     int'(cap[2][16]),  8'hF1);
    check("t6_done_cnt", done_cnt[2],       1);

    check("tx_en_without_rdy", rdy_err[0] + rdy_err[1] + rdy_err[2], 0);
    check("t1_rd_order",       rd_err[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
